baud_gen_frac: RTL and testbench



---
 rtl/baud_gen_frac.sv | 157 +++++++++++++++
 tb/tb_baud_gen_frac.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/baud_gen_frac.sv
// Fractional baud generator: oversample tick, mid-bit and end-of-bit strobes.
// Latency: strobes are registered and rise lim enabled clocks after reset release or restart.
// Backpressure: none; en low freezes all counting state and suppresses strobes.
`timescale 1ns/1ps
module baud_gen_frac #(
    parameter int DVSR_W   = 16,
    parameter int FRAC_W   = 4,
    parameter int OVS      = 16,
    parameter int RST_INT  = 651,
    parameter int RST_FRAC = 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    en,
    input  logic [DVSR_W-1:0]       dvsr_int,
    input  logic [FRAC_W-1:0]       dvsr_frac,
    input  logic                    dvsr_load,
    input  logic                    restart,
    output logic                    tick,
    output logic                    mid_tick,
    output logic                    bit_tick,
    output logic [$clog2(OVS)-1:0]  phase
);

    localparam int PH_W = $clog2(OVS);

    // counting state
    logic [DVSR_W-1:0] cnt_q, cnt_d;
    logic [FRAC_W-1:0] acc_q, acc_d;
    logic              carry_q, carry_d;
    logic [PH_W-1:0]   phase_q, phase_d;

    // divisor in use and divisor waiting for the next period boundary
    logic [DVSR_W-1:0] act_int_q, act_int_d;
    logic [FRAC_W-1:0] act_frac_q, act_frac_d;
    logic [DVSR_W-1:0] pend_int_q, pend_int_d;
    logic [FRAC_W-1:0] pend_frac_q, pend_frac_d;
    logic              pend_vld_q, pend_vld_d;

    // registered strobes
    logic              tick_q, tick_d;
    logic              mid_q, mid_d;
    logic              bit_q, bit_d;

    logic [DVSR_W-1:0] eff;
    logic [DVSR_W:0]   lim_m1;
    logic [FRAC_W:0]   frac_sum;
    logic              tc;

    // Period length: clamp tiny divisors to 2, stretch by one when the last
    // fractional accumulation overflowed. eff >= 2 so lim-1 never underflows.
    always_comb begin
        eff      = (act_int_q < DVSR_W'(2)) ? DVSR_W'(2) : act_int_q;
        lim_m1   = {1'b0, eff} + (DVSR_W+1)'(carry_q) - (DVSR_W+1)'(1);
        frac_sum = {1'b0, acc_q} + {1'b0, act_frac_q};
        tc       = en && ({1'b0, cnt_q} == lim_m1);
    end

    // Next-state: restart beats everything, then terminal count, then loads.
    always_comb begin
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        carry_d     = carry_q;
        phase_d     = phase_q;
        act_int_d   = act_int_q;
        act_frac_d  = act_frac_q;
        pend_int_d  = pend_int_q;
        pend_frac_d = pend_frac_q;
        pend_vld_d  = pend_vld_q;
        tick_d      = 1'b0;
        mid_d       = 1'b0;
        bit_d       = 1'b0;

        if (restart) begin
            cnt_d   = '0;
            acc_d   = '0;
            carry_d = 1'b0;
            phase_d = '0;
            // a load in the same cycle is newer than anything pending
            if (dvsr_load) begin
                act_int_d  = dvsr_int;
                act_frac_d = dvsr_frac;
            end else if (pend_vld_q) begin
                act_int_d  = pend_int_q;
                act_frac_d = pend_frac_q;
            end
            pend_vld_d = 1'b0;
        end else begin
            if (tc) begin
                cnt_d            = '0;
                {carry_d, acc_d} = frac_sum;
                phase_d          = (phase_q == PH_W'(OVS-1)) ? '0 : phase_q + PH_W'(1);
                tick_d           = 1'b1;
                mid_d            = (phase_q == PH_W'(OVS/2-1));
                bit_d            = (phase_q == PH_W'(OVS-1));
                // the period just finished ran on the old divisor; swap now
                if (pend_vld_q) begin
                    act_int_d  = pend_int_q;
                    act_frac_d = pend_frac_q;
                    pend_vld_d = 1'b0;
                end
            end else if (en) begin
                cnt_d = cnt_q + DVSR_W'(1);
            end

            if (dvsr_load) begin
                if (!en) begin
                    // nothing in flight while frozen, so adopt at once
                    act_int_d  = dvsr_int;
                    act_frac_d = dvsr_frac;
                    pend_vld_d = 1'b0;
                end else begin
                    pend_int_d  = dvsr_int;
                    pend_frac_d = dvsr_frac;
                    pend_vld_d  = 1'b1;
                end
            end
        end
    end

    // State registers with asynchronous clear to the power-on divisor.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q       <= '0;
            acc_q       <= '0;
            carry_q     <= 1'b0;
            phase_q     <= '0;
            act_int_q   <= DVSR_W'(RST_INT);
            act_frac_q  <= FRAC_W'(RST_FRAC);
            pend_int_q  <= '0;
            pend_frac_q <= '0;
            pend_vld_q  <= 1'b0;
            tick_q      <= 1'b0;
            mid_q       <= 1'b0;
            bit_q       <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            carry_q     <= carry_d;
            phase_q     <= phase_d;
            act_int_q   <= act_int_d;
            act_frac_q  <= act_frac_d;
            pend_int_q  <= pend_int_d;
            pend_frac_q <= pend_frac_d;
            pend_vld_q  <= pend_vld_d;
            tick_q      <= tick_d;
            mid_q       <= mid_d;
            bit_q       <= bit_d;
        end
    end

    assign tick     = tick_q;
    assign mid_tick = mid_q;
    assign bit_tick = bit_q;
    assign phase    = phase_q;

endmodule

// File: tb/tb_baud_gen_frac.sv
// Bench for baud_gen_frac: expected tick times/strobes are queued from an
// arithmetic period model when stimulus is applied, and popped by a monitor
// as the DUT produces ticks.
`timescale 1ns/1ps
module tb_baud_gen_frac;

    localparam int DVSR_W = 16;
    localparam int FRAC_W = 4;
    localparam int OVS    = 16;

    logic              clk;
    logic              reset_n;
    logic              en;
    logic [DVSR_W-1:0] dvsr_int;
    logic [FRAC_W-1:0] dvsr_frac;
    logic              dvsr_load;
    logic              restart;
    logic              tick;
    logic              mid_tick;
    logic              bit_tick;
    logic [3:0]        phase;

    baud_gen_frac #(
        .DVSR_W(DVSR_W), .FRAC_W(FRAC_W), .OVS(OVS),
        .RST_INT(651), .RST_FRAC(1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .en(en),
        .dvsr_int(dvsr_int), .dvsr_frac(dvsr_frac), .dvsr_load(dvsr_load),
        .restart(restart), .tick(tick), .mid_tick(mid_tick),
        .bit_tick(bit_tick), .phase(phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, want);
        end
    endtask

    typedef struct {
        int   cyc;
        logic mid;
        logic bt;
        int   ph;
    } exp_t;

    exp_t exp_q[$];
    int   seen[$];

    // period model state
    int m_cyc, m_acc, m_carry, m_ph;

    task automatic m_start(input int s);
        m_cyc = s; m_acc = 0; m_carry = 0; m_ph = 0;
    endtask

    task automatic m_ticks(input int dint, input int dfrac, input int n);
        int   eff;
        int   sum;
        exp_t e;
        eff = (dint < 2) ? 2 : dint;
        for (int i = 0; i < n; i++) begin
            m_cyc   = m_cyc + eff + m_carry;
            sum     = m_acc + dfrac;
            m_carry = (sum >= (1 << FRAC_W)) ? 1 : 0;
            m_acc   = sum % (1 << FRAC_W);
            e.cyc   = m_cyc;
            e.mid   = (m_ph == OVS/2 - 1);
            e.bt    = (m_ph == OVS - 1);
            m_ph    = (m_ph + 1) % OVS;
            e.ph    = m_ph;
            exp_q.push_back(e);
        end
    endtask

    // monitor: sample 1 ns after each rising edge
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (tick === 1'b1) begin
            seen.push_back(cyc);
            if (exp_q.size() == 0) begin
                chk("spurious_tick", {31'b0, tick}, 0);
            end else begin
                e = exp_q.pop_front();
                chk("tick_cyc", cyc, e.cyc);
                chk("mid_tick", {31'b0, mid_tick}, {31'b0, e.mid});
                chk("bit_tick", {31'b0, bit_tick}, {31'b0, e.bt});
                chk("phase", {28'b0, phase}, e.ph);
            end
        end else begin
            if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
                chk("missed_tick", cyc, exp_q[0].cyc);
                void'(exp_q.pop_front());
            end
            if (mid_tick !== 1'b0 || bit_tick !== 1'b0)
                chk("strobe_without_tick", {30'b0, mid_tick, bit_tick}, 0);
        end
    end

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("drain", exp_q.size(), 0);
    endtask

    task automatic wait_cyc(input int target);
        for (int i = 0; i < 5000 && cyc < target; i++) @(negedge clk);
    endtask

    task automatic chk_outs_zero(input string tag);
        chk({tag, "_tick"}, {31'b0, tick}, 0);
        chk({tag, "_mid"}, {31'b0, mid_tick}, 0);
        chk({tag, "_bit"}, {31'b0, bit_tick}, 0);
        chk({tag, "_phase"}, {28'b0, phase}, 0);
    endtask

    initial begin
        #(3_000_000);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    int s, c0, c1;

    initial begin
        reset_n = 1'b0; en = 1'b1; dvsr_int = '0; dvsr_frac = '0;
        dvsr_load = 1'b0; restart = 1'b0;
        repeat (3) @(negedge clk);
        chk_outs_zero("reset");

        // power-on divisor 651 + 1/16
        c0 = cyc;
        m_start(c0); m_ticks(651, 1, 17);
        seen.delete();
        reset_n = 1'b1;
        drain(12000);
        chk("t1_count", seen.size(), 17);
        if (seen.size() >= 17) begin
            chk("t1_first", seen[0] - c0, 651);
            chk("t1_span16", seen[16] - seen[0], 10417);
        end

        // divisor loaded while disabled takes effect immediately
        en = 1'b0;
        @(negedge clk); restart = 1'b1;
        @(negedge clk); restart = 1'b0;
        chk("t2_phase_cleared", {28'b0, phase}, 0);
        dvsr_int = 16'd4; dvsr_frac = 4'd0; dvsr_load = 1'b1;
        @(negedge clk); dvsr_load = 1'b0;
        seen.delete();
        s = cyc; m_start(s); m_ticks(4, 0, 32);
        en = 1'b1;
        drain(400);
        chk("t2_count", seen.size(), 32);
        if (seen.size() >= 32) begin
            chk("t2_mid8", seen[7] - s, 32);
            chk("t2_bit16", seen[15] - s, 64);
            chk("t2_bit32", seen[31] - s, 128);
        end

        // fractional half: 4,4,5,4,5,...
        seen.delete();
        s = cyc; restart = 1'b1; dvsr_load = 1'b1; dvsr_int = 16'd4; dvsr_frac = 4'd8;
        m_start(s + 1); m_ticks(4, 8, 33);
        @(negedge clk); restart = 1'b0; dvsr_load = 1'b0;
        drain(400);
        chk("t3_count", seen.size(), 33);
        if (seen.size() >= 33) begin
            chk("t3_first", seen[0] - (s + 1), 4);
            chk("t3_long_period", seen[2] - seen[1], 5);
            chk("t3_span32", seen[32] - seen[0], 144);
        end

        // mid-period load finishes current period on the old divisor
        seen.delete();
        s = cyc; restart = 1'b1; dvsr_load = 1'b1; dvsr_int = 16'd4; dvsr_frac = 4'd0;
        m_start(s + 1); m_ticks(4, 0, 4); m_ticks(10, 0, 3);
        @(negedge clk); restart = 1'b0; dvsr_load = 1'b0;
        wait_cyc(s + 14);
        dvsr_int = 16'd10; dvsr_load = 1'b1;
        @(negedge clk); dvsr_load = 1'b0;
        drain(200);
        chk("t4_count", seen.size(), 7);
        if (seen.size() >= 7) begin
            chk("t4_on_schedule", seen[3] - s, 17);
            chk("t4_new_spacing", seen[4] - seen[3], 10);
        end

        // clamped divisors and restart on a terminal-count cycle
        seen.delete();
        s = cyc; restart = 1'b1; dvsr_load = 1'b1; dvsr_int = 16'd1; dvsr_frac = 4'd0;
        m_start(s + 1); m_ticks(1, 0, 4);
        @(negedge clk); restart = 1'b0; dvsr_load = 1'b0;
        wait_cyc(s + 10);
        restart = 1'b1; dvsr_load = 1'b1; dvsr_int = 16'd0;
        m_start(s + 11); m_ticks(0, 0, 3);
        @(negedge clk); restart = 1'b0; dvsr_load = 1'b0;
        chk("t5_restart_no_tick", {31'b0, tick}, 0);
        chk("t5_restart_phase", {28'b0, phase}, 0);
        drain(100);
        chk("t5_count", seen.size(), 7);
        if (seen.size() >= 7) begin
            chk("t5_after_restart", seen[4] - (s + 11), 2);
            chk("t5_spacing_int0", seen[5] - seen[4], 2);
        end

        // enable drop for 7 cycles mid-period
        seen.delete();
        s = cyc; restart = 1'b1; dvsr_load = 1'b1; dvsr_int = 16'd4; dvsr_frac = 4'd0;
        m_start(s + 1); m_ticks(4, 0, 2); m_cyc = m_cyc + 7; m_ticks(4, 0, 2);
        @(negedge clk); restart = 1'b0; dvsr_load = 1'b0;
        wait_cyc(s + 10);
        en = 1'b0;
        repeat (7) begin
            @(negedge clk);
            chk("t6_hold_tick", {31'b0, tick}, 0);
            chk("t6_hold_phase", {28'b0, phase}, 2);
        end
        en = 1'b1;
        wait_cyc(s + 23);
        @(posedge clk); #2;
        chk("t6_tick_before_reset", {31'b0, tick}, 1);
        chk("t6_count", seen.size(), 4);
        if (seen.size() >= 4)
            chk("t6_delayed_spacing", seen[2] - seen[1], 11);

        // asynchronous reset while a tick is high
        reset_n = 1'b0;
        #1;
        chk_outs_zero("async_reset");
        repeat (3) @(negedge clk);
        seen.delete();
        c1 = cyc; m_start(c1); m_ticks(651, 1, 2);
        reset_n = 1'b1;
        drain(1500);
        chk("t7_count", seen.size(), 2);
        if (seen.size() >= 1)
            chk("t7_first", seen[0] - c1, 651);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
